// File: rtl/slice_sched_pkg.sv
// Shared types and constants for the rotor slice scheduler.
// The default slice geometry lives here; the top derives its own from its parameters.
package slice_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    RUN     = 2'd2
  } sched_state_t;

  localparam int DEF_SLICES_PER_TURN = 128;
  localparam int SLICE_SHIFT         = $clog2(DEF_SLICES_PER_TURN);
  localparam int SLICE_IDX_W         = SLICE_SHIFT;

  function automatic int slice_shift(input int slices);
    return $clog2(slices);
  endfunction

endpackage

// File: rtl/slice_scheduler_hall.sv
// Hall sensor front end: 2-FF synchronizer, low-run filter, falling-edge detect.
// Emits a single-cycle hall_event once SYNC_FILTER consecutive low samples are seen.
module hall_debounce #(
  parameter int SYNC_FILTER = 4
) (
  input  logic clk_enable,
  input  logic nrst,
  input  logic hall_n,
  output logic hall_event
);

  localparam int CW = $clog2(SYNC_FILTER + 1);
  localparam logic [CW-1:0] RUN_DONE = CW'(SYNC_FILTER - 1);
  localparam logic [CW-1:0] RUN_MAX  = CW'(SYNC_FILTER);

  logic          hall_meta;
  logic          hall_sync;
  logic          hall_filt;
  logic [CW-1:0] low_run;

  // The sensor idles high, so the synchronizer resets to the inactive level.
  always_ff @(posedge clk_enable or negedge nrst) begin
    if (!nrst) begin
      hall_meta <= 1'b1;
      hall_sync <= 1'b1;
    end else begin
      hall_meta <= hall_n;
      hall_sync <= hall_meta;
    end
  end

  always_ff @(posedge clk_enable or negedge nrst) begin
    if (!nrst) begin
      low_run    <= '0;
      hall_filt  <= 1'b1;
      hall_event <= 1'b0;
    end else begin
      hall_event <= 1'b0;
      if (hall_sync) begin
        low_run   <= '0;
        hall_filt <= 1'b1;
      end else begin
        if (low_run != RUN_MAX) begin
          low_run <= low_run + CW'(1);
        end
        if (low_run == RUN_DONE && hall_filt) begin
          hall_filt  <= 1'b0;
          hall_event <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/slice_scheduler.sv
// Measures the hall-to-hall rotor period and divides each turn into equal slices,
// emitting a registered position_sync strobe per slice and re-aligning on every hall edge.
module slice_scheduler
  import slice_sched_pkg::*;
#(
  parameter int SLICES_PER_TURN = DEF_SLICES_PER_TURN,
  parameter int PERIOD_W        = 24,
  parameter int MIN_PERIOD      = 1024,
  parameter int SYNC_FILTER     = 4
) (
  input  logic                               clk_enable,
  input  logic                               nrst,
  input  logic                               hall_n,
  output logic                               position_sync,
  output logic                               turn_start,
  output logic [$clog2(SLICES_PER_TURN)-1:0] slice_index,
  output logic                               rotating,
  output logic [PERIOD_W-1:0]                period
);

  localparam int SHIFT = slice_shift(SLICES_PER_TURN);
  localparam int IW    = $clog2(SLICES_PER_TURN);
  localparam int TW    = PERIOD_W - SHIFT;

  localparam logic [IW-1:0]       LAST_IDX = IW'(SLICES_PER_TURN - 1);
  localparam logic [PERIOD_W-1:0] MIN_CNT  = PERIOD_W'(MIN_PERIOD - 1);

  sched_state_t        state;
  logic [PERIOD_W-1:0] cnt;
  logic [PERIOD_W-1:0] interval;
  logic [TW-1:0]       slice_len;
  logic [TW-1:0]       slice_len_new;
  logic [TW-1:0]       slice_timer;
  logic                hall_event;
  logic                timeout;
  logic                accepted;

  hall_debounce #(
    .SYNC_FILTER (SYNC_FILTER)
  ) u_hall (
    .clk_enable (clk_enable),
    .nrst       (nrst),
    .hall_n     (hall_n),
    .hall_event (hall_event)
  );

  // cnt holds ticks-since-event minus one, so the event cycle itself completes the interval.
  assign interval      = cnt + PERIOD_W'(1);
  assign timeout       = &cnt;
  assign accepted      = hall_event && (cnt >= MIN_CNT);
  assign slice_len_new = TW'(interval >> SHIFT);

  always_ff @(posedge clk_enable or negedge nrst) begin
    if (!nrst) begin
      cnt <= '0;
    end else if (accepted) begin
      cnt <= '0;
    end else if (!timeout) begin
      cnt <= cnt + PERIOD_W'(1);
    end
  end

  // A hall edge always wins over a coincident slice expiry, so only the index-0 strobe appears.
  always_ff @(posedge clk_enable or negedge nrst) begin
    if (!nrst) begin
      state         <= IDLE;
      position_sync <= 1'b0;
      turn_start    <= 1'b0;
      slice_index   <= '0;
      rotating      <= 1'b0;
      period        <= '0;
      slice_len     <= '0;
      slice_timer   <= '0;
    end else begin
      position_sync <= 1'b0;
      turn_start    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accepted) begin
            state <= ACQUIRE;
          end
        end
        ACQUIRE, RUN: begin
          if (timeout) begin
            rotating <= 1'b0;
            state    <= accepted ? ACQUIRE : IDLE;
          end else if (accepted) begin
            state         <= RUN;
            rotating      <= 1'b1;
            period        <= interval;
            slice_len     <= slice_len_new;
            slice_timer   <= slice_len_new - TW'(1);
            slice_index   <= '0;
            position_sync <= 1'b1;
            turn_start    <= 1'b1;
          end else if (state == RUN) begin
            if (slice_timer != '0) begin
              slice_timer <= slice_timer - TW'(1);
            end else if (slice_index != LAST_IDX) begin
              slice_index   <= slice_index + IW'(1);
              position_sync <= 1'b1;
              slice_timer   <= slice_len - TW'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slice_scheduler.sv
// Randomized scoreboard bench for slice_scheduler using a scaled geometry (16 slices, 11-bit period)
// so timeouts and many turns fit in a short run.
module tb_slice_scheduler;

  localparam int SLICES    = 16;
  localparam int PW        = 11;
  localparam int MINP      = 128;
  localparam int FILT      = 4;
  localparam int IW        = $clog2(SLICES);
  localparam int LAT       = FILT + 3;
  localparam int SAT       = 1 << PW;
  localparam int PULSE_LOW = 8;

  logic          clk_enable = 1'b0;
  logic          nrst       = 1'b0;
  logic          hall_n     = 1'b1;
  logic          position_sync;
  logic          turn_start;
  logic [IW-1:0] slice_index;
  logic          rotating;
  logic [PW-1:0] period;

  slice_scheduler #(
    .SLICES_PER_TURN (SLICES),
    .PERIOD_W        (PW),
    .MIN_PERIOD      (MINP),
    .SYNC_FILTER     (FILT)
  ) dut (
    .clk_enable    (clk_enable),
    .nrst          (nrst),
    .hall_n        (hall_n),
    .position_sync (position_sync),
    .turn_start    (turn_start),
    .slice_index   (slice_index),
    .rotating      (rotating),
    .period        (period)
  );

  always #5 clk_enable = ~clk_enable;

  int cycle = 0;
  always @(posedge clk_enable) cycle <= cycle + 1;

  typedef struct {
    int cyc;
    int idx;
    int per;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int checks = 0;
  int errors = 0;

  // Reference model: 0 idle, 1 acquiring, 2 running
  int phase      = 0;
  int last_acc   = 0;
  int last_drive = 0;
  int cur_period = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Hall edges are modelled in the cycle where their strobe would appear.
  task automatic model_edge(input int drive_cyc);
    int x;
    int iv;
    int len;
    x  = drive_cyc + LAT;
    iv = x - last_acc;
    if (phase != 0 && iv > SAT) phase = 0;
    if (iv < MINP) return;
    if (phase == 0) begin
      phase = 1;
    end else begin
      while (sb.size() > 0 && sb[sb.size()-1].cyc >= x) sb.delete(sb.size() - 1);
      len = iv / SLICES;
      for (int k = 0; k < SLICES; k++) sb.push_back('{x + k * len, k, iv});
      phase      = 2;
      cur_period = iv;
    end
    last_acc = x;
  endtask

  task automatic applyStimulus(input int gap);
    int target;
    target = last_drive + gap;
    while (cycle < target) begin
      @(posedge clk_enable);
      #1;
    end
    hall_n     = 1'b0;
    last_drive = cycle;
    model_edge(cycle);
    repeat (PULSE_LOW) @(posedge clk_enable);
    #1;
    hall_n = 1'b1;
    checkOutput("rotating_after_edge", int'(rotating), int'(phase == 2));
  endtask

  task automatic short_pulse(input int width);
    hall_n = 1'b0;
    repeat (width) @(posedge clk_enable);
    #1;
    hall_n = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    checkOutput({tag, "_position_sync"}, int'(position_sync), 0);
    checkOutput({tag, "_turn_start"}, int'(turn_start), 0);
    checkOutput({tag, "_slice_index"}, int'(slice_index), 0);
    checkOutput({tag, "_rotating"}, int'(rotating), 0);
    checkOutput({tag, "_period"}, int'(period), 0);
  endtask

  task automatic release_reset();
    @(posedge clk_enable);
    #1;
    nrst       = 1'b1;
    last_acc   = cycle;
    last_drive = cycle;
  endtask

  // Monitor: every strobe must match the head of the scoreboard, and nothing may be overdue.
  always @(negedge clk_enable) begin
    if (nrst) begin
      while (sb.size() > 0 && sb[0].cyc < cycle) begin
        checks++;
        errors++;
        $display("[TB] FAIL missed_strobe: got none expected idx %0d at cycle %0d", sb[0].idx, sb[0].cyc);
        sb.delete(0);
      end
      if (position_sync) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_strobe", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          checkOutput("strobe_cycle", cycle, mon_e.cyc);
          checkOutput("strobe_index", int'(slice_index), mon_e.idx);
          checkOutput("strobe_turn_start", int'(turn_start), int'(mon_e.idx == 0));
          checkOutput("strobe_period", int'(period), mon_e.per);
        end
      end else if (turn_start) begin
        checkOutput("turn_start_alone", 1, 0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    int sel;
    int gap;
    int g;

    repeat (3) @(posedge clk_enable);
    #1;
    check_reset_outputs("reset");
    release_reset();

    // Acquire, then steady rotation, slowdown, speedup and an edge landing on an expiry
    applyStimulus(300);
    applyStimulus(800);
    applyStimulus(800);
    short_pulse(3);
    applyStimulus(800);
    applyStimulus(60);
    applyStimulus(740);
    applyStimulus(880);
    applyStimulus(880);
    applyStimulus(800);
    applyStimulus(400);
    applyStimulus(200);
    applyStimulus(800);

    // Hall stays high until the counter saturates
    while (cycle < last_acc + SAT + 20) begin
      @(posedge clk_enable);
      #1;
    end
    phase = 0;
    checkOutput("timeout_rotating", int'(rotating), 0);
    checkOutput("timeout_slice_index", int'(slice_index), SLICES - 1);
    checkOutput("timeout_period", int'(period), cur_period);
    applyStimulus(700);
    applyStimulus(800);
    applyStimulus(800);

    // Reset in the middle of a turn
    n = 0;
    while (slice_index != IW'(8) && n < 3000) begin
      @(posedge clk_enable);
      #1;
      n++;
    end
    checkOutput("wait_index8_timeout", int'(n >= 3000), 0);
    #1;
    nrst = 1'b0;
    #1;
    sb.delete();
    phase = 0;
    check_reset_outputs("midturn_reset");
    repeat (2) @(posedge clk_enable);
    release_reset();
    applyStimulus(500);
    applyStimulus(800);

    for (int i = 0; i < 20; i++) begin
      sel = $urandom_range(0, 4);
      case (sel)
        0: applyStimulus(800);
        1: applyStimulus($urandom_range(200, 1500));
        2: begin
          gap = (cur_period / SLICES) * $urandom_range(3, 15);
          if (gap < MINP + 20) gap = 800;
          applyStimulus(gap);
        end
        3: begin
          g = $urandom_range(30, 100);
          applyStimulus(g);
          applyStimulus(800 - g);
        end
        default: begin
          repeat ($urandom_range(100, 500)) @(posedge clk_enable);
          #1;
          short_pulse(3);
          applyStimulus(800);
        end
      endcase
    end

    n = 0;
    while (sb.size() > 0 && n < 3000) begin
      @(posedge clk_enable);
      #1;
      n++;
    end
    checkOutput("scoreboard_drained", sb.size(), 0);
    repeat (20) @(posedge clk_enable);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
